// File: rtl/arbiter_for_mem.sv
// Round-robin arbiter granting the node's single memory port to the download
// engine, the data-cache miss path or the instruction-cache miss path.
module arbiter_for_mem (
  input  logic clk,
  input  logic rst,
  input  logic v_mem_download,
  input  logic v_d_m_areg,
  input  logic v_i_m_areg,
  input  logic mem_access_done,
  output logic ack_m_download,
  output logic ack_d_m_areg,
  output logic ack_i_m_areg,
  output logic v_m_download_m,
  output logic v_d_m_areg_m,
  output logic v_i_m_areg_m
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_MEM  = 2'd1,
    G_DC   = 2'd2,
    G_IC   = 2'd3
  } grant_t;

  state_t state_q, state_d;
  grant_t grant_q, grant_d;
  grant_t ptr_q, ptr_d;
  grant_t winner;
  logic   busy_live;

  // Requester that follows g in the rotation MEM -> DC -> IC -> MEM.
  function automatic grant_t next_req(input grant_t g);
    grant_t n;
    case (g)
      G_MEM:   n = G_DC;
      G_DC:    n = G_IC;
      G_IC:    n = G_MEM;
      default: n = G_MEM;
    endcase
    return n;
  endfunction

  always_comb begin
    winner = G_NONE;
    case (ptr_q)
      G_DC: begin
        if (v_d_m_areg)          winner = G_DC;
        else if (v_i_m_areg)     winner = G_IC;
        else if (v_mem_download) winner = G_MEM;
      end
      G_IC: begin
        if (v_i_m_areg)          winner = G_IC;
        else if (v_mem_download) winner = G_MEM;
        else if (v_d_m_areg)     winner = G_DC;
      end
      default: begin
        if (v_mem_download)      winner = G_MEM;
        else if (v_d_m_areg)     winner = G_DC;
        else if (v_i_m_areg)     winner = G_IC;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (winner != G_NONE) begin
          state_d = BUSY;
          grant_d = winner;
        end
      end
      BUSY: begin
        // Requests are deliberately not looked at here: the grant is held
        // until the memory controller says the access is finished.
        if (mem_access_done) begin
          state_d = IDLE;
          grant_d = G_NONE;
          ptr_d   = next_req(grant_q);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = G_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= G_NONE;
      ptr_q   <= G_MEM;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // Outputs are forced low during reset so an aborted access never acks.
  assign busy_live = (state_q == BUSY) && !rst;

  assign v_m_download_m = busy_live && (grant_q == G_MEM);
  assign v_d_m_areg_m   = busy_live && (grant_q == G_DC);
  assign v_i_m_areg_m   = busy_live && (grant_q == G_IC);

  assign ack_m_download = v_m_download_m && mem_access_done;
  assign ack_d_m_areg   = v_d_m_areg_m   && mem_access_done;
  assign ack_i_m_areg   = v_i_m_areg_m   && mem_access_done;

endmodule

// File: tb/tb_arbiter_for_mem.sv
// Scoreboard bench for arbiter_for_mem: a requester/memory driver feeds a
// round-robin reference model, a monitor compares the DUT against its queues.
module tb_arbiter_for_mem;

  logic clk = 1'b0;
  logic rst;
  logic v_mem_download, v_d_m_areg, v_i_m_areg, mem_access_done;
  logic ack_m_download, ack_d_m_areg, ack_i_m_areg;
  logic v_m_download_m, v_d_m_areg_m, v_i_m_areg_m;

  arbiter_for_mem dut (
    .clk             (clk),
    .rst             (rst),
    .v_mem_download  (v_mem_download),
    .v_d_m_areg      (v_d_m_areg),
    .v_i_m_areg      (v_i_m_areg),
    .mem_access_done (mem_access_done),
    .ack_m_download  (ack_m_download),
    .ack_d_m_areg    (ack_d_m_areg),
    .ack_i_m_areg    (ack_i_m_areg),
    .v_m_download_m  (v_m_download_m),
    .v_d_m_areg_m    (v_d_m_areg_m),
    .v_i_m_areg_m    (v_i_m_areg_m)
  );

  always #5 clk = ~clk;

  // Requester index: 0 = download (MEM), 1 = data cache, 2 = instruction cache.
  logic [5:0] cyc_q[$];
  int         grant_q[$];
  int         ack_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  bit         sim_done = 0;

  bit m_busy = 0;
  bit m_new  = 0;
  int m_owner = 0;
  int m_ptr   = 0;

  task automatic checkOutput(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Drives one cycle of inputs and advances the reference model by one cycle.
  task automatic applyStimulus(input bit r, input bit [2:0] rq, input bit d,
                               output int acked);
    logic [5:0] expv;
    rst             = r;
    v_mem_download  = rq[0];
    v_d_m_areg      = rq[1];
    v_i_m_areg      = rq[2];
    mem_access_done = d;
    expv  = '0;
    acked = -1;
    if (r) begin
      m_busy = 0;
      m_new  = 0;
      m_ptr  = 0;
    end else if (m_busy) begin
      if (m_new) begin
        grant_q.push_back(m_owner);
        m_new = 0;
      end
      expv[m_owner] = 1'b1;
      if (d) begin
        expv[3 + m_owner] = 1'b1;
        ack_q.push_back(m_owner);
        acked  = m_owner;
        m_busy = 0;
        m_ptr  = (m_owner + 1) % 3;
      end
    end else if (rq != 3'b000) begin
      for (int k = 2; k >= 0; k--)
        if (rq[(m_ptr + k) % 3]) m_owner = (m_ptr + k) % 3;
      m_busy = 1;
      m_new  = 1;
    end
    cyc_q.push_back(expv);
  endtask

  initial begin
    bit [2:0] pend;
    bit [2:0] just_acked;
    int       acked, busy_cnt, done_delay;
    bit       was_busy, directed, r, d;

    rst = 1'b1;
    v_mem_download = 1'b0;
    v_d_m_areg = 1'b0;
    v_i_m_areg = 1'b0;
    mem_access_done = 1'b0;
    pend = 3'b111;
    just_acked = 3'b000;
    busy_cnt = 0;
    done_delay = 3;

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 3'b111, 1'b0, acked);
    end

    for (int c = 0; c < 1600; c++) begin
      @(negedge clk);
      directed = (c < 40);
      if (m_busy) d = (busy_cnt >= done_delay);
      else        d = ($urandom_range(0, 7) == 0);
      r = !directed && (($urandom_range(0, 59) == 0) ||
                        (m_busy && d && $urandom_range(0, 4) == 0));
      for (int i = 0; i < 3; i++)
        if (!pend[i] && !just_acked[i])
          pend[i] = directed ? 1'b1 : ($urandom_range(0, 2) == 0);
      if (!directed && m_busy && $urandom_range(0, 9) == 0) pend[m_owner] = 1'b0;

      was_busy = m_busy;
      applyStimulus(r, pend, d, acked);
      if (m_busy && m_new) begin
        busy_cnt   = 0;
        done_delay = directed ? 3 : $urandom_range(0, 4);
      end else if (was_busy && m_busy) begin
        busy_cnt++;
      end
      just_acked = 3'b000;
      if (acked >= 0) begin
        pend[acked] = 1'b0;
        just_acked[acked] = 1'b1;
      end
    end

    @(negedge clk);
    sim_done = 1;
  end

  function automatic int idx_of(input logic [2:0] v);
    if (v[0]) return 0;
    if (v[1]) return 1;
    return 2;
  endfunction

  initial begin
    logic [2:0] vv, aa;
    logic [2:0] prev_v;
    logic [5:0] expv;
    prev_v = 3'b000;
    forever begin
      @(negedge clk);
      #2;
      if (sim_done) break;
      vv = {v_i_m_areg_m, v_d_m_areg_m, v_m_download_m};
      aa = {ack_i_m_areg, ack_d_m_areg, ack_m_download};

      if (cyc_q.size() == 0) checkOutput("cycle_queue_empty", 1, 0);
      else begin
        expv = cyc_q.pop_front();
        checkOutput("cycle_outputs{ack,v}", {aa, vv}, expv);
      end

      checkOutput("grant_onehot0", int'($onehot0(vv)), 1);
      checkOutput("ack_onehot0", int'($onehot0(aa)), 1);
      checkOutput("ack_implies_grant", aa & ~vv, 0);

      if (vv != 3'b000 && prev_v == 3'b000) begin
        if (grant_q.size() == 0) checkOutput("unexpected_grant", idx_of(vv), -1);
        else checkOutput("grant_winner", idx_of(vv), grant_q.pop_front());
      end
      if (aa != 3'b000) begin
        if (ack_q.size() == 0) checkOutput("unexpected_ack", idx_of(aa), -1);
        else checkOutput("ack_target", idx_of(aa), ack_q.pop_front());
      end
      prev_v = vv;
    end
    checkOutput("grants_left_unseen", grant_q.size(), 0);
    checkOutput("acks_left_unseen", ack_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
